vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Timing generator directly downstream of the 25 MHz pixel-enable divider.
- Consumes the one-clock-wide pixel enable pulse (pix_en, asserted 1 in 4 system clocks) and advances horizontal and vertical counters.
- Produces HSYNC, VSYNC, the visible-area flag and current pixel coordinates for the pixel generator and VGA pins.
- Default timing: 640x480 @ 60 Hz.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-low reset
- pix_en  input  1  pixel enable; one clk cycle high per pixel period
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- video_on  output  1  high while (h_cnt < H_VIS) and (v_cnt < V_VIS)
- pixel_x  output  10  current h_cnt
- pixel_y  output  10  current v_cnt
- line_start  output  1  one-clk pulse when h_cnt becomes 0
- frame_start  output  1  one-clk pulse when (h_cnt, v_cnt) becomes (0, 0)

Behaviour:
- Derived constants: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525). Counters are 10 bits; parameters must keep H_TOT and V_TOT at or below 1024.
- Reset (reset = 0, async): h_cnt = H_TOT-1 (799), v_cnt = V_TOT-1 (524).
- Reset values of the outputs:
  - hsync = vsync = inactive (~SYNC_POL).
  - video_on = 0; line_start = 0; frame_start = 0.
  - pixel_x = 799; pixel_y = 524.
- Counters update only on a clk edge with pix_en = 1; otherwise they hold.
  - h_cnt: if h_cnt == H_TOT-1 then 0, else h_cnt+1.
  - v_cnt changes only when h_cnt wraps: if v_cnt == V_TOT-1 then 0, else v_cnt+1.
- First pix_en after reset release wraps both counters to (0,0) and pulses frame_start and line_start.
- All outputs are registered.
  - Decode from next-state counter values so each output is valid in the same cycle its counter value appears. No combinational path from counters to pins.
- Sync windows:
  - hsync active when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
  - vsync active when V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
- Pulse timing:
  - line_start and frame_start are high for exactly the one clk cycle following the pix_en edge that produced the wrap.
  - They are low for the remaining cycles of that pixel period.
- pix_en held high continuously is legal: the counters advance every clk.
- A reset asserted mid-line or mid-frame immediately forces the reset values, with no completion of the current line.
- Counter values outside the legal range cannot be reached, so no recovery logic is required.

Test Plan:
- Release reset, apply pix_en 1-in-4 -> on the first pix_en, pixel_x = 0, pixel_y = 0, frame_start and line_start are high for 1 clk, video_on = 1.
- Run one full line -> hsync low for exactly 96 pix_en periods, starting at pixel_x = 656; line period = 800 pix_en = 3200 clk.
- Run a full frame -> vsync low for lines 490 and 491 only (2 x 800 pix_en); frame period = 420000 pix_en; frame_start pulses once.
- Check video_on across a frame -> high for exactly 640x480 = 307200 pix_en periods; low at (640, y), at (x, 480) and during reset.
- Hold pix_en = 0 for 100 clk at pixel_x = 300 -> all outputs frozen; line_start and frame_start stay low.
- Assert reset at (400, 250) -> outputs immediately return to the reset values (799, 524, syncs inactive); after release, the next pix_en yields (0, 0) and a frame_start pulse.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable driven horizontal/vertical counters with
// registered sync, visible-area and line/frame start outputs.
module vga_sync_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_MAX  = 10'(H_TOT - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_TOT - 1);
  // 11-bit window bounds so a 1024-wide timing still compares correctly
  localparam logic [10:0] H_VEND = 11'(H_VIS);
  localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_VEND = 11'(V_VIS);
  localparam logic [10:0] VS_BEG = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic        ACT    = (SYNC_POL != 0);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_vis;

  // Decode from the next counter values so outputs line up with the counters.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_MAX);
    w_h_nxt  = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
    end
    w_hs_act = ({1'b0, w_h_nxt} >= HS_BEG) && ({1'b0, w_h_nxt} < HS_END);
    w_vs_act = ({1'b0, w_v_nxt} >= VS_BEG) && ({1'b0, w_v_nxt} < VS_END);
    w_vis    = ({1'b0, w_h_nxt} < H_VEND) && ({1'b0, w_v_nxt} < V_VEND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt       <= H_MAX;
      r_v_cnt       <= V_MAX;
      r_hsync       <= ~ACT;
      r_vsync       <= ~ACT;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_h_cnt       <= w_h_nxt;
        r_v_cnt       <= w_v_nxt;
        r_hsync       <= w_hs_act ? ACT : ~ACT;
        r_vsync       <= w_vs_act ? ACT : ~ACT;
        r_video_on    <= w_vis;
        r_line_start  <= (w_h_nxt == 10'd0);
        r_frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
